hazard_stall_controller: RTL



---
 rtl/hazard_stall_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hold/flush/bubble sequencer for the 5-stage RV32I core: load-use stalls,
// taken-branch flushes and multi-cycle data-memory waits, plus debug counters.
`timescale 1ns/1ps
module hazard_stall_controller #(
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ma_mem_req,
  input  logic             ma_mem_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_ma_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ma_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_MEM_WAIT - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             flush_pending_r;
  logic             flush_pending_next_s;
  logic [7:0]       wait_cnt_r;
  logic             mem_timeout_r;
  logic [CNT_W-1:0] stall_cycles_r;
  logic             mem_stall_s;
  logic             load_use_s;
  logic             do_flush_s;

  assign mem_stall_s = ma_mem_req & ~ma_mem_ready;
  assign load_use_s  = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));
  // The wrong-path fetch must be dropped in FLUSH, or on the release of a wait that parked a flush.
  assign do_flush_s  = (state_r == FLUSH) | ((state_r == MEM_WAIT) & flush_pending_r);

  // State and parked-flush register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= RUN;
      flush_pending_r <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      flush_pending_r <= flush_pending_next_s;
    end
  end

  // Next-state selection with mem_stall > flush > branch priority.
  always_comb begin
    state_next_s         = RUN;
    flush_pending_next_s = 1'b0;
    if (mem_stall_s) begin
      state_next_s = MEM_WAIT;
      if ((state_r == FLUSH) || ex_branch_taken) begin
        flush_pending_next_s = 1'b1;
      end else begin
        flush_pending_next_s = flush_pending_r;
      end
    end else if (do_flush_s) begin
      state_next_s = RUN;
    end else if (ex_branch_taken) begin
      state_next_s = FLUSH;
    end else begin
      state_next_s = RUN;
    end
  end

  // Pipeline-register controls, combinational from state and inputs.
  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_hold   = 1'b0;
    ex_ma_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ma_wb_bubble = 1'b0;
    if (mem_stall_s) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_hold   = 1'b1;
      ex_ma_hold   = 1'b1;
      ma_wb_bubble = 1'b1;
    end else if (do_flush_s) begin
      if_id_flush  = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use_s) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      pc_hold      = 1'b0;
    end
  end

  // Consecutive-wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r     <= 8'd0;
      mem_timeout_r  <= 1'b0;
      stall_cycles_r <= {CNT_W{1'b0}};
    end else begin
      if (mem_stall_s) begin
        if (wait_cnt_r != 8'hFF) begin
          wait_cnt_r <= wait_cnt_r + 8'd1;
        end
        if (wait_cnt_r >= WAIT_LAST) begin
          mem_timeout_r <= 1'b1;
        end
      end else begin
        wait_cnt_r <= 8'd0;
      end
      if (pc_hold && (stall_cycles_r != {CNT_W{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign state        = state_r;
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_cycles_r;

endmodule
